// File: rtl/nco_tuning_controller.sv
// nco_tuning_controller
// Feeds a phase increment word to an NCO and produces the NCO sample enable.
// New increments are taken over a valid/ready handshake and applied only on a
// sample boundary, so the NCO never sees a change mid-sample.
// Optional linear frequency sweep: define NCO_SWEEP_EN to build the SWEEP
// state, the sweep step adder and the sweep_done pulse. Without it the sweep
// ports stay on the boundary, sweep_start is ignored and sweep_done is 0.
module nco_tuning_controller #(
    parameter int PHASE_WIDTH     = 64,
    parameter int CE_DIV_WIDTH    = 16,
    parameter int SWEEP_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       arst_n,
    input  logic [CE_DIV_WIDTH-1:0]    ce_div,
    input  logic                       tune_valid,
    input  logic [PHASE_WIDTH-1:0]     tune_increment,
    output logic                       tune_ready,
    input  logic                       sweep_start,
    input  logic [PHASE_WIDTH-1:0]     sweep_step,
    input  logic [SWEEP_CNT_WIDTH-1:0] sweep_count,
    output logic                       sample_clk_ce,
    output logic [PHASE_WIDTH-1:0]     phase_increment,
    output logic                       busy,
    output logic                       sweep_done
);

    localparam logic [CE_DIV_WIDTH-1:0] DIV_ONE = CE_DIV_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
`ifdef NCO_SWEEP_EN
        ST_SWEEP   = 2'd2,
`endif
        ST_PENDING = 2'd1
    } state_t;

    state_t                  state;
    state_t                  state_nx;
    logic                    tune_ready_nx;
    logic [CE_DIV_WIDTH-1:0] div_cnt;
    logic                    wrap;
    logic                    tune_acc;
    logic                    tune_load;
    logic [PHASE_WIDTH-1:0]  tune_q;

    // The divider wraps on this cycle; sample_clk_ce is high the cycle after.
    // Using >= means a lowered ce_div wraps at once instead of stalling.
    assign wrap = (div_cnt >= ce_div);

    // A tune request is taken only in IDLE with the registered ready high.
    assign tune_acc = (state == ST_IDLE) && tune_ready && tune_valid;

    // Load the tuned word on any wrap while it is outstanding. An acceptance
    // that coincides with a wrap loads straight from the input, so the change
    // lands on the first sample pulse after the acceptance cycle.
    assign tune_load = wrap && (tune_acc || (state == ST_PENDING));

    // Sample enable divider: counts 0..ce_div and emits a one-cycle pulse
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            div_cnt       <= '0;
            sample_clk_ce <= 1'b0;
        end else if (wrap) begin
            div_cnt       <= '0;
            sample_clk_ce <= 1'b1;
        end else begin
            div_cnt       <= div_cnt + DIV_ONE;
            sample_clk_ce <= 1'b0;
        end
    end

    // Holding register for an accepted tune word until its sample boundary
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            tune_q <= '0;
        end else if (tune_acc) begin
            tune_q <= tune_increment;
        end
    end

`ifdef NCO_SWEEP_EN
    localparam logic [SWEEP_CNT_WIDTH-1:0] CNT_ONE = SWEEP_CNT_WIDTH'(1);

    logic                       sweep_acc;
    logic                       sweep_active;
    logic                       sweep_tick;
    logic                       sweep_fin;
    logic [PHASE_WIDTH-1:0]     step_q;
    logic [PHASE_WIDTH-1:0]     step_eff;
    logic [SWEEP_CNT_WIDTH-1:0] remain_q;
    logic [SWEEP_CNT_WIDTH-1:0] remain_eff;

    // A simultaneous tune request takes priority and the sweep is dropped.
    assign sweep_acc = (state == ST_IDLE) && tune_ready && sweep_start && !tune_valid;

    // Sweep step/finish decode; live inputs on the start cycle, latched copies after
    always_comb begin
        sweep_active = sweep_acc || (state == ST_SWEEP);
        step_eff     = (state == ST_SWEEP) ? step_q : sweep_step;
        remain_eff   = (state == ST_SWEEP) ? remain_q : sweep_count;
        sweep_tick   = sweep_active && wrap && (remain_eff != '0);
        // Finish on the wrap that applies the last step, or at once for a zero count
        sweep_fin    = sweep_active &&
                       ((remain_eff == '0) || (wrap && (remain_eff == CNT_ONE)));
    end

    // Latched sweep parameters, remaining step count and the done pulse
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            step_q     <= '0;
            remain_q   <= '0;
            sweep_done <= 1'b0;
        end else begin
            sweep_done <= sweep_fin;
            if (sweep_active) begin
                step_q   <= step_eff;
                remain_q <= sweep_tick ? (remain_eff - CNT_ONE) : remain_eff;
            end
        end
    end
`else
    logic unused_sweep;

    // Sweep inputs are kept on the boundary but have no function in this build
    assign unused_sweep = ^{sweep_start, sweep_step, sweep_count};
    assign sweep_done   = 1'b0;
`endif

    // Phase increment register: changes only on wraps, i.e. visible with sample_clk_ce
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            phase_increment <= '0;
        end else if (tune_load) begin
            phase_increment <= tune_acc ? tune_increment : tune_q;
`ifdef NCO_SWEEP_EN
        end else if (sweep_tick) begin
            phase_increment <= phase_increment + step_eff;
`endif
        end
    end

    // FSM state register, with tune_ready registered from the next state
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state      <= ST_IDLE;
            tune_ready <= 1'b0;
        end else begin
            state      <= state_nx;
            tune_ready <= tune_ready_nx;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (tune_acc) begin
                    state_nx = ST_PENDING;
`ifdef NCO_SWEEP_EN
                end else if (sweep_acc && !sweep_fin) begin
                    state_nx = ST_SWEEP;
`endif
                end
            end
            // The first pulse seen in PENDING already carries the new word
            ST_PENDING: begin
                if (sample_clk_ce) begin
                    state_nx = ST_IDLE;
                end
            end
`ifdef NCO_SWEEP_EN
            ST_SWEEP: begin
                if (sweep_fin) begin
                    state_nx = ST_IDLE;
                end
            end
`endif
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: ready follows the next state, busy follows the current state
    always_comb begin
        tune_ready_nx = (state_nx == ST_IDLE);
        busy          = (state != ST_IDLE);
    end

endmodule
